// File: rtl/lfsr_pkg.sv
// Definitions shared by the 12-bit PRBS generator and its receive-side checker.
// Both sides take their feedback from lfsr_fb, so the two cannot drift apart.
package lfsr_pkg;

    localparam int              LFSR_N    = 12;
    localparam logic [LFSR_N-1:0] LFSR_TAPS = 12'h829;
    localparam logic [LFSR_N-1:0] LFSR_SEED = 12'hC0D;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_N-1:0] r);
        return ^(r & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: fills a local LFSR from the line, confirms
// the prediction for LOCK_CNT bits, then flywheels and counts bit errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int N          = 12,
    parameter int LOCK_CNT   = 16,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      bit_count,
    output logic [1:0]       state
);

    localparam int FW  = $clog2(N + 1);
    localparam int MW  = $clog2(LOCK_CNT + 1);
    localparam int WW  = $clog2(WINDOW + 1);
    localparam int EW  = $clog2(ERR_THRESH + 1);

    chk_state_t       state_q, state_d;
    logic [N-1:0]     reg_q, reg_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      bit_cnt_q, bit_cnt_d;
    logic             err_pulse_q, err_pulse_d;

    logic             pred;
    logic             mism;
    logic [N-1:0]     shift_din;
    logic [N-1:0]     shift_pred;

    assign pred       = lfsr_fb(reg_q);
    assign mism       = din ^ pred;
    assign shift_din  = {reg_q[N-2:0], din};
    assign shift_pred = {reg_q[N-2:0], pred};

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_pulse_d = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    reg_d = shift_din;
                    if (fill_q == FW'(N - 1)) begin
                        fill_d = '0;
                        // An all-zero fill is the LFSR lockup state; keep hunting.
                        if (shift_din != '0) begin
                            state_d   = VERIFY;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (!mism) begin
                        reg_d = shift_pred;
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d   = LOCKED;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        state_d   = HUNT;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                LOCKED: begin
                    reg_d = shift_pred;
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (win_cnt_q == WW'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        if (mism) begin
                            win_err_d = win_err_q + 1'b1;
                        end
                    end
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        // The threshold test sees this error even on a window-closing bit.
                        if (win_err_q == EW'(ERR_THRESH - 1)) begin
                            state_d   = HUNT;
                            fill_d    = '0;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        if (clear_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            reg_q       <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign bit_count = bit_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker against a history-based reference model
// of the lock / flywheel / window rules.
module tb_lfsr_checker;

    localparam int LOCK_CNT   = 16;
    localparam int WINDOW     = 64;
    localparam int ERR_THRESH = 4;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic             din;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [31:0]      bit_count;
    logic [1:0]       state;

    always #5 clk = ~clk;

    lfsr_checker #(
        .N(12), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW),
        .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count), .state(state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: the local copy is a queue of the last 12 tracked bits,
    // oldest first; the prediction is the recurrence b[n] = b[n-1]^b[n-4]^b[n-6]^b[n-12].
    int          m_state, m_fill, m_match, m_wcnt, m_werr;
    bit          hist[$];
    longint      m_errc, m_bits;
    bit          m_pulse;

    function automatic void m_reset();
        hist.delete();
        for (int i = 0; i < 12; i++) hist.push_back(1'b0);
        m_state = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
        m_errc = 0; m_bits = 0; m_pulse = 0;
    endfunction

    function automatic bit m_pred();
        return hist[11] ^ hist[8] ^ hist[6] ^ hist[0];
    endfunction

    function automatic void m_push(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endfunction

    function automatic void m_step(input bit v, input bit d, input bit clr);
        bit p;
        bit any;
        m_pulse = 0;
        if (v) begin
            p = m_pred();
            if (m_state == 0) begin
                m_push(d);
                m_fill++;
                if (m_fill == 12) begin
                    m_fill = 0;
                    any = 0;
                    foreach (hist[i]) any |= hist[i];
                    if (any) begin m_state = 1; m_match = 0; end
                end
            end else if (m_state == 1) begin
                if (d == p) begin
                    m_push(p);
                    m_match++;
                    if (m_match == LOCK_CNT) begin m_state = 2; m_wcnt = 0; m_werr = 0; end
                end else begin
                    m_state = 0; m_fill = 0;
                end
            end else begin
                m_push(p);
                if (m_bits < 64'hFFFF_FFFF) m_bits++;
                m_wcnt++;
                if (d != p) begin
                    m_pulse = 1;
                    if (m_errc < (1 << CNT_W) - 1) m_errc++;
                    m_werr++;
                end
                if (m_werr == ERR_THRESH) begin
                    m_state = 0; m_fill = 0;
                end else if (m_wcnt == WINDOW) begin
                    m_wcnt = 0; m_werr = 0;
                end
            end
        end
        if (clr) begin m_errc = 0; m_bits = 0; end
    endfunction

    // Generator stand-in: Fibonacci LFSR, newest bit enters at bit 0.
    logic [11:0] g;
    function automatic bit gen_next();
        bit b;
        b = g[0];
        g = {g[10:0], g[0] ^ g[3] ^ g[5] ^ g[11]};
        return b;
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, ".state"},  32'(state),     32'(m_state));
        check_eq({tag, ".locked"}, 32'(locked),    32'(m_state == 2));
        check_eq({tag, ".pulse"},  32'(err_pulse), 32'(m_pulse));
        check_eq({tag, ".errc"},   32'(err_count), 32'(m_errc));
        check_eq({tag, ".bits"},   bit_count,      32'(m_bits));
    endtask

    task automatic cyc(input bit v, input bit d, input bit clr);
        @(negedge clk);
        din_valid = v; din = d; clear_cnt = clr;
        @(posedge clk);
        m_step(v, d, clr);
        #1;
        compare_all("cyc");
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, gen_next(), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; din_valid = 1'b0; din = 1'b0; clear_cnt = 1'b0;
        #1;
        m_reset();
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;
        g = 12'hC0D;
    endtask

    initial begin
        reset = 1'b1; din_valid = 1'b0; din = 1'b0; clear_cnt = 1'b0;
        m_reset();
        g = 12'hC0D;
        repeat (3) @(posedge clk);
        #1;
        compare_all("por");
        check_eq("por_state", 32'(state), 0);
        @(negedge clk);
        reset = 1'b0;

        // Clean lock from seed 0xC0D
        clean(12);
        check_eq("clean_in_verify", 32'(state), 1);
        clean(15);
        check_eq("clean_27_unlocked", 32'(locked), 0);
        clean(1);
        check_eq("clean_28_locked", 32'(locked), 1);
        check_eq("clean_state2", 32'(state), 2);
        clean(4095);
        check_eq("clean_errc0", 32'(err_count), 0);
        check_eq("clean_bits4095", bit_count, 4095);
        $display("txn clean_lock state=%0d bits=%0d errc=%0d", state, bit_count, err_count);

        // Single error while locked
        clean($urandom_range(1, 40));
        cyc(1'b1, ~gen_next(), 1'b0);
        check_eq("single_pulse_hi", 32'(err_pulse), 1);
        check_eq("single_errc1", 32'(err_count), 1);
        check_eq("single_locked", 32'(locked), 1);
        clean(1);
        check_eq("single_pulse_lo", 32'(err_pulse), 0);
        clean(100);
        check_eq("single_flywheel", 32'(err_count), 1);
        $display("txn single_error errc=%0d locked=%0d", err_count, locked);

        // Loss of lock: four errors inside one window
        cyc(1'b0, 1'b0, 1'b1);
        check_eq("lol_cleared", 32'(err_count), 0);
        for (int i = 0; i < WINDOW && m_wcnt != 0; i++) clean(1);
        for (int k = 0; k < ERR_THRESH; k++) begin
            clean($urandom_range(0, 10));
            cyc(1'b1, ~gen_next(), 1'b0);
            check_eq("lol_locked_after_err", 32'(locked), (k == ERR_THRESH - 1) ? 0 : 1);
        end
        check_eq("lol_state0", 32'(state), 0);
        check_eq("lol_errc4", 32'(err_count), 4);
        clean(27);
        check_eq("lol_relock_27", 32'(locked), 0);
        clean(1);
        check_eq("lol_relock_28", 32'(locked), 1);
        check_eq("lol_errc_kept", 32'(err_count), 4);
        $display("txn loss_of_lock errc=%0d locked=%0d", err_count, locked);

        // Counter priority: clear coincident with an error
        clean(5);
        cyc(1'b1, ~gen_next(), 1'b1);
        check_eq("prio_errc0", 32'(err_count), 0);
        check_eq("prio_pulse", 32'(err_pulse), 1);
        check_eq("prio_bits0", bit_count, 0);
        $display("txn clear_priority errc=%0d pulse=%0d", err_count, err_pulse);

        // Lockup guard
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
        check_eq("lockup_hunt", 32'(state), 0);
        check_eq("lockup_unlocked", 32'(locked), 0);
        clean(27);
        check_eq("lockup_27", 32'(locked), 0);
        clean(1);
        check_eq("lockup_28", 32'(locked), 1);
        $display("txn lockup_guard state=%0d", state);

        // VERIFY abort with din_valid every third cycle
        do_reset();
        for (int b = 1; b <= 48; b++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (b == 20) cyc(1'b1, ~gen_next(), 1'b0);
            else         cyc(1'b1, gen_next(), 1'b0);
            if (b == 20) begin
                check_eq("abort_hunt", 32'(state), 0);
                check_eq("abort_nopulse", 32'(err_pulse), 0);
            end
            if (b == 47) check_eq("abort_47", 32'(locked), 0);
        end
        check_eq("abort_relock", 32'(locked), 1);
        check_eq("abort_errc0", 32'(err_count), 0);
        $display("txn verify_abort state=%0d errc=%0d", state, err_count);

        // Asynchronous reset while in VERIFY
        do_reset();
        clean(15);
        check_eq("rst_in_verify", 32'(state), 1);
        @(negedge clk);
        reset = 1'b1; din_valid = 1'b0;
        #1;
        m_reset();
        compare_all("async_rst");
        check_eq("async_rst_state", 32'(state), 0);
        @(negedge clk);
        reset = 1'b0;
        g = 12'hC0D;
        clean(28);
        check_eq("rst_relock", 32'(locked), 1);
        $display("txn reset_in_verify locked=%0d", locked);

        // Randomised soak with varying error density and gaps
        for (int blk = 0; blk < 20; blk++) begin
            int rate;
            rate = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 200 : 8);
            for (int i = 0; i < 1000; i++) begin
                bit v, e, c;
                v = ($urandom_range(0, 3) != 0);
                e = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
                c = ($urandom_range(0, 499) == 0);
                if (v) cyc(1'b1, gen_next() ^ e, c);
                else   cyc(1'b0, 1'($urandom_range(0, 1)), c);
            end
            $display("txn soak_block %0d rate=%0d state=%0d errc=%0d bits=%0d",
                     blk, rate, state, err_count, bit_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
